hnm_row_decoder: RTL and testbench

//  Inverse of the HNM SSID write path. HNM writes SSID={row,col} as one set bit in an NCOLS_HNM-wide row.

---
 rtl/hnm_row_decoder.sv | 103 ++++++++++
 tb/tb_hnm_row_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hnm_row_decoder.sv
// rtl/hnm_row_decoder.sv - HNM row bitmap to SSID stream decoder, one SSID per set bit, lowest column first
// Optional HNM_DECODER_COUNT_EN adds a saturating count of accepted SSIDs (ssidCount, satCount).
module hnm_row_decoder #(
    parameter int ROWINDEXBITS_HNM = 8,
    parameter int COLINDEXBITS_HNM = 4,
    parameter int NCOLS_HNM        = 16,
    parameter int SSIDBITS         = ROWINDEXBITS_HNM + COLINDEXBITS_HNM
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        rowValid,
    output logic                        rowReady,
    input  logic [ROWINDEXBITS_HNM-1:0] rowIndex,
    input  logic [NCOLS_HNM-1:0]        rowData,
    output logic                        ssidValid,
    input  logic                        ssidReady,
    output logic [SSIDBITS-1:0]         SSID_out,
    output logic                        lastSSID,
    output logic                        busy
`ifdef HNM_DECODER_COUNT_EN
    ,
    output logic [15:0]                 ssidCount,
    output logic                        satCount
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                      state, nextState;
    logic [NCOLS_HNM-1:0]        mask, nextMask, maskLowCleared;
    logic [ROWINDEXBITS_HNM-1:0] rowReg, nextRow;
    logic [COLINDEXBITS_HNM-1:0] col;

    // Clearing the lowest set bit is the same as clearing bit col.
    assign maskLowCleared = mask & (mask - NCOLS_HNM'(1));

    always_comb begin
        col = '0;
        for (int i = NCOLS_HNM - 1; i >= 0; i--) begin
            if (mask[i]) col = COLINDEXBITS_HNM'(i);
        end
    end

    always_comb begin
        nextState = state;
        nextMask  = mask;
        nextRow   = rowReg;
        rowReady  = 1'b0;
        ssidValid = 1'b0;
        busy      = 1'b0;
        lastSSID  = 1'b0;
        SSID_out  = '0;
        case (state)
            IDLE: begin
                rowReady = 1'b1;
                if (rowValid) begin
                    nextRow  = rowIndex;
                    nextMask = rowData;
                    if (rowData != '0) nextState = SCAN;
                end
            end
            SCAN: begin
                busy      = 1'b1;
                ssidValid = 1'b1;
                SSID_out  = SSIDBITS'({rowReg, col});
                lastSSID  = (maskLowCleared == '0);
                if (ssidReady) begin
                    nextMask = maskLowCleared;
                    if (maskLowCleared == '0) nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mask   <= '0;
            rowReg <= '0;
        end else begin
            state  <= nextState;
            mask   <= nextMask;
            rowReg <= nextRow;
        end
    end

`ifdef HNM_DECODER_COUNT_EN
    logic ssidFire;
    assign ssidFire = ssidValid & ssidReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ssidCount <= '0;
            satCount  <= 1'b0;
        end else if (ssidFire) begin
            if (ssidCount != 16'hFFFF) ssidCount <= ssidCount + 16'd1;
            if (ssidCount >= 16'hFFFE) satCount <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hnm_row_decoder.sv
// tb/tb_hnm_row_decoder.sv - scoreboard bench for hnm_row_decoder with randomized rows and backpressure
module tb_hnm_row_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rowValid = 1'b0;
    logic        rowReady;
    logic [7:0]  rowIndex = '0;
    logic [15:0] rowData = '0;
    logic        ssidValid;
    logic        ssidReady = 1'b0;
    logic [11:0] SSID_out;
    logic        lastSSID;
    logic        busy;
`ifdef HNM_DECODER_COUNT_EN
    logic [15:0] ssidCount;
    logic        satCount;
`endif

    int nChecks = 0;
    int nFails = 0;
    int popCount = 0;
    int readyMode = 0;
    logic [12:0] expQ[$];

    always #5 clk = ~clk;

    hnm_row_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rowValid  (rowValid),
        .rowReady  (rowReady),
        .rowIndex  (rowIndex),
        .rowData   (rowData),
        .ssidValid (ssidValid),
        .ssidReady (ssidReady),
        .SSID_out  (SSID_out),
        .lastSSID  (lastSSID),
        .busy      (busy)
`ifdef HNM_DECODER_COUNT_EN
        ,
        .ssidCount (ssidCount),
        .satCount  (satCount)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s: actual timeout required completion", name);
    endtask

    // Reference: one SSID per set bit, ascending column, last flag on the highest set column.
    task automatic pushRow(input logic [7:0] idx, input logic [15:0] d);
        int hi;
        hi = -1;
        for (int c = 0; c < 16; c++) if (d[c]) hi = c;
        for (int c = 0; c < 16; c++) if (d[c]) expQ.push_back({(c == hi), idx, 4'(c)});
    endtask

    task automatic sendRow(input logic [7:0] idx, input logic [15:0] d, output int waitCycles);
        pushRow(idx, d);
        @(posedge clk);
        #1;
        rowValid = 1'b1;
        rowIndex = idx;
        rowData  = d;
        waitCycles = 0;
        forever begin
            @(negedge clk);
            waitCycles++;
            if (rowReady) break;
            if (waitCycles > 300) begin
                timeoutFail("row_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        rowValid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (expQ.size() == 0 && rowReady) break;
            n++;
            if (n > 1000) begin
                timeoutFail(name);
                expQ.delete();
                break;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       ssidReady = 1'b1;
            1:       ssidReady = ~ssidReady;
            default: ssidReady = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic        prevStall = 1'b0;
    logic [11:0] prevSsid = '0;
    logic        prevLast = 1'b0;
    logic [12:0] e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            check("rowReady_vs_ssidValid", rowReady, !ssidValid);
            check("busy_vs_ssidValid", busy, ssidValid);
            if (prevStall) begin
                check("stall_valid", ssidValid, 1'b1);
                check("stall_ssid", SSID_out, prevSsid);
                check("stall_last", lastSSID, prevLast);
            end
            if (ssidValid && ssidReady) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_ssid: actual 0x%0h required none", SSID_out);
                end else begin
                    e = expQ.pop_front();
                    check("ssid", SSID_out, e[11:0]);
                    check("lastSSID", lastSSID, e[12]);
                    popCount++;
                end
            end
            prevStall = ssidValid && !ssidReady;
            prevSsid  = SSID_out;
            prevLast  = lastSSID;
        end
    end

    task automatic checkResetOutputs(input string tag);
        check({tag, "_rowReady"}, rowReady, 1'b1);
        check({tag, "_ssidValid"}, ssidValid, 1'b0);
        check({tag, "_SSID_out"}, SSID_out, 12'h000);
        check({tag, "_lastSSID"}, lastSSID, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int w;
        int lowCnt;
        int base;
        int n;

        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        #2;
        reset_n = 1'b1;

        readyMode = 0;
        sendRow(8'd4, 16'h1056, w);
        waitIdle("test1_idle");
        check("test1_rowReady", rowReady, 1'b1);

        readyMode = 1;
        sendRow(8'd8, 16'h0989, w);
        waitIdle("test2_idle");

`ifdef HNM_DECODER_COUNT_EN
        check("count_after_1_2", ssidCount, 16'd10);
        check("sat_after_1_2", satCount, 1'b0);
`endif

        readyMode = 0;
        sendRow(8'd3, 16'h0000, w);
        check("zero_row_accept_cycles", w, 1);
        @(negedge clk);
        check("zero_row_busy", busy, 1'b0);
        check("zero_row_ssidValid", ssidValid, 1'b0);
        sendRow(8'd9, 16'h0080, w);
        waitIdle("test3_idle");

        sendRow(8'd12, 16'hFFFF, w);
        lowCnt = 0;
        forever begin
            @(negedge clk);
            if (rowReady || lowCnt > 100) break;
            lowCnt++;
        end
        check("full_row_busy_cycles", lowCnt, 16);
        waitIdle("test4_idle");

        base = popCount;
        sendRow(8'd2, 16'h00F0, w);
        n = 0;
        while (popCount < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (popCount < base + 2) timeoutFail("test5_two_ssids");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        expQ.delete();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        sendRow(8'd1, 16'h0100, w);
        waitIdle("test5_idle");

        readyMode = 2;
        for (int r = 0; r < 30; r++) begin
            logic [7:0]  ri;
            logic [15:0] rd;
            ri = 8'($urandom);
            rd = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            sendRow(ri, rd, w);
        end
        waitIdle("random_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running required finished");
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1);
    end

endmodule
